md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 149 ++++++++++++++
 tb/tb_md_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit holding the architectural HI/LO pair.
//
// An operation is accepted in IDLE when start=1 and md_op is a legal non-zero code.
// The result is computed from the operands at acceptance and parked in a pending
// register. It is committed to HI/LO when the down-counter expires: 5 cycles for a
// multiply and 10 for a divide. MTHI/MTLO write HI/LO at the next edge without
// going busy.
//
// Build option: define MD_UNIT_MADD_EN to make md_op=7 a signed multiply-accumulate
// into {HI,LO}. Without the macro, md_op=7 is a no-op and no accumulate adder exists.
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   synchronous, active-high
//   start  in   1   E-stage instruction is a mult/div-class op
//   md_op  in   3   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD
//   A      in  32   forwarded rs operand
//   B      in  32   forwarded rt operand
//   busy   out  1   registered, an operation is in flight
//   HI     out 32   registered architectural HI
//   LO     out 32   registered architectural LO

module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] pend_q, pend_d;   // {HI,LO} to commit when cnt expires

    // Full 64-bit product. The operands are sign- or zero-extended to 64 bits,
    // so the low 64 bits of the 64x64 product are exact for both signednesses.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ea, eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes, so
    // 0x80000000 / -1 yields 0x80000000 with remainder 0 without overflow.
    // The quotient truncates toward zero and the remainder takes the dividend's sign.
    // A zero divisor yields remainder = dividend and quotient = all ones.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end
        ma = (sgn && a[31]) ? (~a + 32'd1) : a;
        mb = (sgn && b[31]) ? (~b + 32'd1) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (sgn && (a[31] ^ b[31])) q = ~q + 32'd1;
        if (sgn && a[31])           r = ~r + 32'd1;
        return {r, q};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        3'd1, 3'd2: begin
                            pend_d  = mul64(A, B, md_op == 3'd1);
                            cnt_d   = MUL_CYCLES;
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        3'd3, 3'd4: begin
                            pend_d  = div64(A, B, md_op == 3'd3);
                            cnt_d   = DIV_CYCLES;
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        3'd5: hi_d = A;
                        3'd6: lo_d = A;
`ifdef MD_UNIT_MADD_EN
                        3'd7: begin
                            // The accumulate base is the HI/LO value at acceptance.
                            pend_d  = {hi_q, lo_q} + mul64(A, B, 1'b1);
                            cnt_d   = MUL_CYCLES;
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    {hi_d, lo_d} = pend_q;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- directed-vector bench for md_unit with hand-computed expected values.
// Define MD_UNIT_MADD_EN for both the bench and the RTL to exercise the MADD build.

module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_errors = 0;

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multi-cycle op, check busy and HI/LO hold for n cycles, then check
    // the committed result. A conflicting start is injected while busy and must be ignored.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] old_hi, old_lo;
        old_hi = HI;
        old_lo = LO;
        start = 1'b1; md_op = op; A = a; B = b;
        tick();
        start = 1'b0; md_op = 3'd0; A = 32'hDEAD_BEEF; B = 32'h0000_0001;
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, {63'd0, busy}, 64'd1);
            check({tag, "_hold_hi"}, {32'd0, HI}, {32'd0, old_hi});
            check({tag, "_hold_lo"}, {32'd0, LO}, {32'd0, old_lo});
            if (i == 2) begin
                start = 1'b1; md_op = 3'd1; A = 32'd7; B = 32'd9;
            end else begin
                start = 1'b0; md_op = 3'd0;
            end
            tick();
        end
        start = 1'b0; md_op = 3'd0;
        check({tag, "_done_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_hi"}, {32'd0, HI}, {32'd0, eh});
        check({tag, "_lo"}, {32'd0, LO}, {32'd0, el});
    endtask

    task automatic move(input logic [2:0] op, input logic [31:0] a);
        start = 1'b1; md_op = op; A = a; B = 32'd0;
        tick();
        start = 1'b0; md_op = 3'd0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
        tick();
        tick();
        check("rst_hi", {32'd0, HI}, 64'd0);
        check("rst_lo", {32'd0, LO}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;

        // Back-to-back ops: each start lands in the cycle right after busy falls.
        run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("divu", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        // After the ignored start, the unit must stay idle with the result intact.
        tick();
        check("ignored_busy", {63'd0, busy}, 64'd0);
        check("ignored_lo", {32'd0, LO}, 64'd14);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div0", 3'd3, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
        run_op("divu0", 3'd4, 32'h8000_0001, 32'd0, 10, 32'h8000_0001, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_mix", 3'd1, 32'hFFFF_FFFF, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // Zero-latency moves.
        move(3'd6, 32'h0000_1234);
        check("mtlo_lo", {32'd0, LO}, 64'h1234);
        check("mtlo_hi", {32'd0, HI}, 64'hFFFF_FFFF);
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        move(3'd5, 32'h0000_ABCD);
        check("mthi_hi", {32'd0, HI}, 64'hABCD);
        check("mthi_busy", {63'd0, busy}, 64'd0);

        // md_op=0 with start is a no-op.
        move(3'd0, 32'h5555_5555);
        check("nop_hi", {32'd0, HI}, 64'hABCD);
        check("nop_lo", {32'd0, LO}, 64'h1234);
        check("nop_busy", {63'd0, busy}, 64'd0);

        // Multiply-accumulate, or a no-op when the feature is not built.
        move(3'd5, 32'd0);
        move(3'd6, 32'd10);
`ifdef MD_UNIT_MADD_EN
        run_op("madd", 3'd7, 32'd2, 32'd3, 5, 32'd0, 32'd16);
        move(3'd5, 32'hFFFF_FFFF);
        move(3'd6, 32'hFFFF_FFFF);
        run_op("madd_wrap", 3'd7, 32'd1, 32'd1, 5, 32'd0, 32'd0);
`else
        move(3'd7, 32'd2);
        check("madd_off_busy", {63'd0, busy}, 64'd0);
        tick();
        tick();
        tick();
        tick();
        tick();
        check("madd_off_lo", {32'd0, LO}, 64'd10);
        check("madd_off_hi", {32'd0, HI}, 64'd0);
`endif

        // Reset discards an in-flight multiply.
        move(3'd6, 32'h7777);
        start = 1'b1; md_op = 3'd1; A = 32'd3; B = 32'd4;
        tick();
        start = 1'b0; md_op = 3'd0;
        check("abort_busy_pre", {63'd0, busy}, 64'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_hi", {32'd0, HI}, 64'd0);
        check("abort_lo", {32'd0, LO}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 6; i++) tick();
        check("abort_late_lo", {32'd0, LO}, 64'd0);
        check("abort_late_hi", {32'd0, HI}, 64'd0);
        check("abort_late_busy", {63'd0, busy}, 64'd0);

        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1; md_op = 3'd6; A = 32'h55;
        tick();
        reset = 1'b0; start = 1'b0; md_op = 3'd0;
        check("rst_prio_lo", {32'd0, LO}, 64'd0);
        check("rst_prio_busy", {63'd0, busy}, 64'd0);

        // A multiply straight out of reset still works.
        run_op("post_rst", 3'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
